// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the divide sequencer and its unsigned core.
package muldiv_pkg;

  localparam int BITS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ZERO = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Number of set bits in a register-stage mask, i.e. the core pipeline depth.
  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage request/response bundle for the divide sequencer.
interface div_ctrl_if
  import muldiv_pkg::*;
#(
  parameter int BITS = BITS_DEF
);
  logic            start;
  logic            is_signed;
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic            hi_we;
  logic            lo_we;
  logic [BITS-1:0] wdata;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [BITS-1:0] hi;
  logic [BITS-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_ctrl_div.sv
// Unsigned restoring divider, one quotient bit per stage; stage i is registered
// when COUNTER[i] is set. Quotient comes out on hi, remainder on low.
module div
  import muldiv_pkg::*;
#(
  parameter int              BITS    = BITS_DEF,
  parameter logic [BITS-1:0] COUNTER = '0
) (
  input  logic            clock,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] hi,
  output logic [BITS-1:0] low
);

  // With an all-zero mask the core is purely combinational.
  logic            clock_unused;
  logic [BITS-1:0] b_unused;

  assign clock_unused = clock;

  for (genvar i = 0; i < BITS; i++) begin : g_stage
    logic [BITS-1:0] r_i, q_i, b_i;
    logic [BITS-1:0] r_o, q_o, b_o;
    logic [BITS-1:0] r_d, q_d;
    logic [BITS:0]   rem_sh, diff;

    if (i == 0) begin : g_first
      assign r_i = '0;
      assign q_i = a;
      assign b_i = b;
    end else begin : g_next
      assign r_i = g_stage[i-1].r_o;
      assign q_i = g_stage[i-1].q_o;
      assign b_i = g_stage[i-1].b_o;
    end

    always_comb begin
      rem_sh = {r_i, q_i[BITS-1]};
      diff   = rem_sh - {1'b0, b_i};
      if (diff[BITS]) begin
        r_d = rem_sh[BITS-1:0];
        q_d = {q_i[BITS-2:0], 1'b0};
      end else begin
        r_d = diff[BITS-1:0];
        q_d = {q_i[BITS-2:0], 1'b1};
      end
    end

    if (COUNTER[i]) begin : g_reg
      logic [BITS-1:0] r_q, q_q, b_q;
      always_ff @(posedge clock) begin
        r_q <= r_d;
        q_q <= q_d;
        b_q <= b_i;
      end
      assign r_o = r_q;
      assign q_o = q_q;
      assign b_o = b_q;
    end else begin : g_comb
      assign r_o = r_d;
      assign q_o = q_d;
      assign b_o = b_i;
    end
  end

  assign hi       = g_stage[BITS-1].q_o;
  assign low      = g_stage[BITS-1].r_o;
  assign b_unused = g_stage[BITS-1].b_o;

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer: feeds operand magnitudes to the unsigned core, waits out its
// latency, sign-corrects the result and owns the HI (remainder) / LO (quotient) registers.
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | counting down core latency
// FIX   | sign-correct core result into HI/LO
// ZERO  | divisor was zero: LO = all-ones, HI = raw dividend
module div_ctrl
  import muldiv_pkg::*;
#(
  parameter int              BITS    = BITS_DEF,
  parameter logic [BITS-1:0] COUNTER = '0,
  parameter int              LATENCY = 0
) (
  input  logic     clock,
  input  logic     reset,
  div_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(BITS + 1);

  if (popcount(64'(COUNTER)) != LATENCY) begin : g_bad_latency
    $error("div_ctrl: LATENCY must equal the number of set bits in COUNTER");
  end

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [BITS-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d, raw_a_q, raw_a_d;
  logic [BITS-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            div_zero_q, div_zero_d, done_q, done_d;
  logic [BITS-1:0] core_quo, core_rem;

  div #(
    .BITS    (BITS),
    .COUNTER (COUNTER)
  ) u_div (
    .clock (clock),
    .a     (mag_a_q),
    .b     (mag_b_q),
    .hi    (core_quo),
    .low   (core_rem)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    raw_a_d    = raw_a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    if (bus.hi_we) hi_d = bus.wdata;
    if (bus.lo_we) lo_d = bus.wdata;

    case (state_q)
      IDLE: begin
        // The done cycle still belongs to the finishing op, so a start there is dropped.
        if (bus.start && !done_q) begin
          sa_d    = bus.is_signed & bus.op_a[BITS-1];
          sb_d    = bus.is_signed & bus.op_b[BITS-1];
          mag_a_d = sa_d ? -bus.op_a : bus.op_a;
          mag_b_d = sb_d ? -bus.op_b : bus.op_b;
          raw_a_d = bus.op_a;
          if (bus.op_b == '0) begin
            state_d = ZERO;
          end else begin
            cnt_d   = CNT_W'(LATENCY);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        lo_d       = (sa_q ^ sb_q) ? -core_quo : core_quo;
        hi_d       = sa_q ? -core_rem : core_rem;
        div_zero_d = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      ZERO: begin
        lo_d       = '1;
        hi_d       = raw_a_q;
        div_zero_d = 1'b1;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      raw_a_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      raw_a_q    <= raw_a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench: two divide sequencers (latency 0 and latency 4) driven by the same stimulus.
module tb_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, is_signed, hi_we, lo_we;
  logic [31:0] op_a, op_b, wdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  div_ctrl_if #(.BITS(32)) if0 ();
  div_ctrl_if #(.BITS(32)) if4 ();

  assign if0.start = start;     assign if4.start = start;
  assign if0.is_signed = is_signed; assign if4.is_signed = is_signed;
  assign if0.op_a = op_a;       assign if4.op_a = op_a;
  assign if0.op_b = op_b;       assign if4.op_b = op_b;
  assign if0.hi_we = hi_we;     assign if4.hi_we = hi_we;
  assign if0.lo_we = lo_we;     assign if4.lo_we = lo_we;
  assign if0.wdata = wdata;     assign if4.wdata = wdata;

  div_ctrl #(.BITS(32), .COUNTER(32'h0000_0000), .LATENCY(0)) dut0 (
    .clock (clock), .reset (reset), .bus (if0)
  );
  div_ctrl #(.BITS(32), .COUNTER(32'h8080_8080), .LATENCY(4)) dut4 (
    .clock (clock), .reset (reset), .bus (if4)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle 1 after the start edge.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    tick();
    is_signed = sgn;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_both(input int first, output int c0, output int c4);
    c0 = 0;
    c4 = 0;
    for (int cyc = first; cyc <= first + 20; cyc++) begin
      if (if0.done === 1'b1 && c0 == 0) c0 = cyc;
      if (if4.done === 1'b1 && c4 == 0) c4 = cyc;
      if (c0 != 0 && c4 != 0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({if0.busy, if0.done, if0.div_zero} !== 3'b000 || {if0.hi, if0.lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset dut0: busy/done/dz=%b%b%b hi=%h lo=%h want all zero",
               if0.busy, if0.done, if0.div_zero, if0.hi, if0.lo);
    end
    checks++;
    if ({if4.busy, if4.done, if4.div_zero} !== 3'b000 || {if4.hi, if4.lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset dut4: busy/done/dz=%b%b%b hi=%h lo=%h want all zero",
               if4.busy, if4.done, if4.div_zero, if4.hi, if4.lo);
    end
  endtask

  task automatic test_divide();
    vec_t vecs [8];
    int   c0, c4;
    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'h10,         32'd0,          32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_both(1, c0, c4);
      checks++;
      if (c0 !== 3) begin
        errors++;
        $display("FAIL div v%0d dut0 done cycle: got %0d want 3", i, c0);
      end
      checks++;
      if (c4 !== 7) begin
        errors++;
        $display("FAIL div v%0d dut4 done cycle: got %0d want 7", i, c4);
      end
      checks++;
      if (if0.lo !== vecs[i].lo || if0.hi !== vecs[i].hi) begin
        errors++;
        $display("FAIL div v%0d dut0 lo/hi: got %h/%h want %h/%h", i, if0.lo, if0.hi, vecs[i].lo, vecs[i].hi);
      end
      checks++;
      if (if4.lo !== vecs[i].lo || if4.hi !== vecs[i].hi) begin
        errors++;
        $display("FAIL div v%0d dut4 lo/hi: got %h/%h want %h/%h", i, if4.lo, if4.hi, vecs[i].lo, vecs[i].hi);
      end
      checks++;
      if (if0.done !== 1'b0 || if0.div_zero !== 1'b0 || if4.div_zero !== 1'b0) begin
        errors++;
        $display("FAIL div v%0d dut0 done pulse/div_zero: got done=%b dz=%b%b want 0 00",
                 i, if0.done, if0.div_zero, if4.div_zero);
      end
      tick();
      checks++;
      if (if4.done !== 1'b0) begin
        errors++;
        $display("FAIL div v%0d dut4 done pulse: got %b want 0", i, if4.done);
      end
    end
  endtask

  task automatic test_div_zero();
    int c0, c4;
    start_op(1'b0, 32'h1234, 32'd0);
    wait_both(1, c0, c4);
    checks++;
    if (c0 !== 2 || c4 !== 2) begin
      errors++;
      $display("FAIL zero done cycle: got %0d/%0d want 2/2", c0, c4);
    end
    checks++;
    if (if0.lo !== 32'hFFFF_FFFF || if0.hi !== 32'h1234 || if0.div_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero dut0: lo=%h hi=%h dz=%b want ffffffff 00001234 1", if0.lo, if0.hi, if0.div_zero);
    end
    checks++;
    if (if4.lo !== 32'hFFFF_FFFF || if4.hi !== 32'h1234 || if4.div_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero dut4: lo=%h hi=%h dz=%b want ffffffff 00001234 1", if4.lo, if4.hi, if4.div_zero);
    end
    tick();
    tick();
    tick();
    checks++;
    if (if0.div_zero !== 1'b1 || if4.div_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero sticky: got %b/%b want 1/1", if0.div_zero, if4.div_zero);
    end
    start_op(1'b1, 32'hFFFF_FFF0, 32'd0);
    wait_both(1, c0, c4);
    checks++;
    if (if0.hi !== 32'hFFFF_FFF0 || if4.hi !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL zero raw hi: got %h/%h want fffffff0", if0.hi, if4.hi);
    end
    start_op(1'b0, 32'd9, 32'd3);
    wait_both(1, c0, c4);
    checks++;
    if (c0 !== 3 || c4 !== 7) begin
      errors++;
      $display("FAIL zero next-op done cycle: got %0d/%0d want 3/7", c0, c4);
    end
    checks++;
    if (if0.lo !== 32'd3 || if0.hi !== 32'd0 || if0.div_zero !== 1'b0 ||
        if4.lo !== 32'd3 || if4.hi !== 32'd0 || if4.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL zero clear: dut0 %h/%h/%b dut4 %h/%h/%b want 3/0/0",
               if0.lo, if0.hi, if0.div_zero, if4.lo, if4.hi, if4.div_zero);
    end
  endtask

  task automatic test_busy_start();
    int c0, c4, n;
    start_op(1'b0, 32'd100, 32'd7);
    checks++;
    if (if0.busy !== 1'b1 || if4.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy after start: got %b/%b want 1/1", if0.busy, if4.busy);
    end
    start = 1'b1;
    op_a  = 32'd50;
    op_b  = 32'd5;
    tick();
    start = 1'b0;
    wait_both(2, c0, c4);
    checks++;
    if (c0 !== 3 || c4 !== 7) begin
      errors++;
      $display("FAIL busy_start done cycle: got %0d/%0d want 3/7", c0, c4);
    end
    checks++;
    if (if0.lo !== 32'd14 || if0.hi !== 32'd2 || if4.lo !== 32'd14 || if4.hi !== 32'd2) begin
      errors++;
      $display("FAIL busy_start result: dut0 %h/%h dut4 %h/%h want e/2", if0.lo, if0.hi, if4.lo, if4.hi);
    end
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if0.done === 1'b1 || if4.done === 1'b1) n++;
    end
    checks++;
    if (n !== 0 || if0.busy !== 1'b0 || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start queued op: extra done=%0d busy=%b/%b want 0 0/0", n, if0.busy, if4.busy);
    end
  endtask

  task automatic test_back_to_back();
    int n0, c4;
    start_op(1'b0, 32'd20, 32'd4);
    tick();
    tick();
    checks++;
    if (if0.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b dut0 done at cycle 3: got %b want 1", if0.done);
    end
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'd2;
    tick();
    start = 1'b0;
    checks++;
    if (if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b start on done accepted: busy got %b want 0", if0.busy);
    end
    n0 = 0;
    c4 = 0;
    for (int cyc = 4; cyc <= 14; cyc++) begin
      if (if0.done === 1'b1) n0++;
      if (if4.done === 1'b1 && c4 == 0) c4 = cyc;
      tick();
    end
    checks++;
    if (n0 !== 0 || c4 !== 7) begin
      errors++;
      $display("FAIL b2b extra done dut0=%0d dut4 cycle=%0d want 0 7", n0, c4);
    end
    checks++;
    if (if0.lo !== 32'd5 || if0.hi !== 32'd0 || if4.lo !== 32'd5 || if4.hi !== 32'd0) begin
      errors++;
      $display("FAIL b2b result: dut0 %h/%h dut4 %h/%h want 5/0", if0.lo, if0.hi, if4.lo, if4.hi);
    end
  endtask

  task automatic test_write_collision();
    int c0, c4;
    tick();
    wdata = 32'hAAAA;
    lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    checks++;
    if (if0.lo !== 32'hAAAA || if4.lo !== 32'hAAAA) begin
      errors++;
      $display("FAIL wr lo idle: got %h/%h want 0000aaaa", if0.lo, if4.lo);
    end
    wdata = 32'h5555;
    hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    checks++;
    if (if0.hi !== 32'h5555 || if4.hi !== 32'h5555) begin
      errors++;
      $display("FAIL wr hi idle: got %h/%h want 00005555", if0.hi, if4.hi);
    end
    start_op(1'b0, 32'd20, 32'd5);
    tick();
    wdata = 32'hAAAA;
    lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    wait_both(3, c0, c4);
    checks++;
    if (c0 !== 3 || c4 !== 7) begin
      errors++;
      $display("FAIL wr collision done cycle: got %0d/%0d want 3/7", c0, c4);
    end
    checks++;
    if (if0.lo !== 32'd4 || if0.hi !== 32'd0 || if4.lo !== 32'd4 || if4.hi !== 32'd0) begin
      errors++;
      $display("FAIL wr collision result: dut0 %h/%h dut4 %h/%h want 4/0", if0.lo, if0.hi, if4.lo, if4.hi);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    start_op(1'b0, 32'd100, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.hi !== 32'd0 || if0.lo !== 32'd0) begin
      errors++;
      $display("FAIL abort dut0: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", if0.busy, if0.done, if0.hi, if0.lo);
    end
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.hi !== 32'd0 || if4.lo !== 32'd0) begin
      errors++;
      $display("FAIL abort dut4: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", if4.busy, if4.done, if4.hi, if4.lo);
    end
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if0.done === 1'b1 || if4.done === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL abort late done: got %0d pulses want 0", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    wdata     = '0;
    test_reset();
    test_divide();
    test_div_zero();
    test_busy_start();
    test_back_to_back();
    test_write_collision();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
